// File: rtl/bus_host_arbiter_if.sv
// Host-side and device-side bus bundle for bus_host_arbiter.
// The arbiter takes the slave view; the hosts and the device sit on the master view.
interface bus_host_arbiter_if #(
    parameter int NrHosts   = 3,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    logic [NrHosts-1:0]                  host_req_i;
    logic [NrHosts-1:0]                  host_gnt_o;
    logic [NrHosts-1:0][AddrWidth-1:0]   host_addr_i;
    logic [NrHosts-1:0]                  host_we_i;
    logic [NrHosts-1:0][DataWidth/8-1:0] host_be_i;
    logic [NrHosts-1:0][DataWidth-1:0]   host_wdata_i;
    logic [NrHosts-1:0]                  host_rvalid_o;
    logic [NrHosts-1:0][DataWidth-1:0]   host_rdata_o;
    logic [NrHosts-1:0]                  host_err_o;

    logic                                dev_req_o;
    logic                                dev_gnt_i;
    logic [AddrWidth-1:0]                dev_addr_o;
    logic                                dev_we_o;
    logic [DataWidth/8-1:0]              dev_be_o;
    logic [DataWidth-1:0]                dev_wdata_o;
    logic                                dev_rvalid_i;
    logic [DataWidth-1:0]                dev_rdata_i;
    logic                                dev_err_i;

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o
    );
endinterface

// File: rtl/bus_host_arbiter.sv
// Shares one device port among NrHosts hosts and routes in-order responses back via an ID FIFO.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module bus_host_arbiter #(
    parameter int NrHosts        = 3,
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    bus_host_arbiter_if.slave bus,
    output logic              orphan_o
);
    localparam int IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [IdW-1:0]  r_ids [MaxOutstanding];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;

    logic [IdW-1:0]  w_sel;
    logic [IdW-1:0]  w_head;
    logic            w_any;
    logic            w_eligible;
    logic            w_hs;
    logic            w_pop;
    int              w_idx;

    function automatic logic [PtrW-1:0] f_ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [IdW-1:0] r_last;

    // Walk from farthest to nearest so the host just after r_last wins.
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        w_idx = 0;
        for (int i = NrHosts; i >= 1; i--) begin
            w_idx = (int'(r_last) + i) % NrHosts;
            if (bus.host_req_i[w_idx]) begin
                w_sel = IdW'(w_idx);
                w_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_last <= IdW'(NrHosts - 1);
        end else if (w_hs) begin
            r_last <= w_sel;
        end
    end
`else
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        w_idx = 0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            w_idx = i;
            if (bus.host_req_i[w_idx]) begin
                w_sel = IdW'(w_idx);
                w_any = 1'b1;
            end
        end
    end
`endif

    // Full blocks requests even when a response pops this cycle: no rvalid-to-grant path.
    assign w_eligible    = (r_count < CntW'(MaxOutstanding));
    assign bus.dev_req_o = rst_ni & w_any & w_eligible;
    assign w_hs          = bus.dev_req_o & bus.dev_gnt_i;
    assign w_head        = r_ids[r_rptr];
    assign w_pop         = rst_ni & bus.dev_rvalid_i & (r_count != '0);
    assign orphan_o      = rst_ni & bus.dev_rvalid_i & (r_count == '0);

    assign bus.host_rdata_o = {NrHosts{bus.dev_rdata_i}};

    always_comb begin
        bus.dev_addr_o  = '0;
        bus.dev_we_o    = 1'b0;
        bus.dev_be_o    = '0;
        bus.dev_wdata_o = '0;
        if (w_any) begin
            bus.dev_addr_o  = bus.host_addr_i[w_sel];
            bus.dev_we_o    = bus.host_we_i[w_sel];
            bus.dev_be_o    = bus.host_be_i[w_sel];
            bus.dev_wdata_o = bus.host_wdata_i[w_sel];
        end
    end

    always_comb begin
        bus.host_gnt_o    = '0;
        bus.host_rvalid_o = '0;
        bus.host_err_o    = '0;
        if (w_hs) begin
            bus.host_gnt_o[w_sel] = 1'b1;
        end
        if (w_pop) begin
            bus.host_rvalid_o[w_head] = 1'b1;
            bus.host_err_o[w_head]    = bus.dev_err_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_hs) begin
                r_wptr <= f_ptr_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_next(r_rptr);
            end
            if (w_hs && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_hs && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_hs) begin
            r_ids[r_wptr] <= w_sel;
        end
    end
endmodule

// File: tb/tb_bus_host_arbiter.sv
// Scoreboard bench for bus_host_arbiter: directed stimulus queues expected grants/responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_bus_host_arbiter;
    localparam int NH = 3;

    typedef struct packed {
        logic [2:0]  rv;
        logic [31:0] data;
        logic [2:0]  err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic orphan;
    int   checks = 0;
    int   failures = 0;

    logic [2:0] exp_gnt[$];
    rsp_t       exp_rsp[$];
    bit         exp_orph[$];
    rsp_t       mon_e;

    always #5 clk = ~clk;

    bus_host_arbiter_if #(.NrHosts(NH), .DataWidth(32), .AddrWidth(32)) bif ();

    bus_host_arbiter #(
        .NrHosts(NH), .DataWidth(32), .AddrWidth(32), .MaxOutstanding(2)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bus     (bif.slave),
        .orphan_o(orphan)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic rsp_t mk_rsp(input logic [2:0] rv, input logic [31:0] d, input logic [2:0] e);
        return {rv, d, e};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.host_req_i   = '0;
        bif.dev_gnt_i    = 1'b0;
        bif.dev_rvalid_i = 1'b0;
        bif.dev_rdata_i  = '0;
        bif.dev_err_i    = 1'b0;
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (|bif.host_gnt_o) begin
                if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(bif.host_gnt_o), 64'(0));
                else chk("gnt", 64'(bif.host_gnt_o), 64'(exp_gnt.pop_front()));
            end
            if (|bif.host_rvalid_o) begin
                if (exp_rsp.size() == 0) begin
                    chk("rvalid_unexpected", 64'(bif.host_rvalid_o), 64'(0));
                end else begin
                    mon_e = exp_rsp.pop_front();
                    chk("rvalid", 64'(bif.host_rvalid_o), 64'(mon_e.rv));
                    chk("err", 64'(bif.host_err_o), 64'(mon_e.err));
                    for (int h = 0; h < NH; h++) begin
                        if (mon_e.rv[h]) chk("rdata", 64'(bif.host_rdata_o[h]), 64'(mon_e.data));
                    end
                end
            end
            if (orphan) begin
                if (exp_orph.size() == 0) chk("orphan_unexpected", 64'(orphan), 64'(0));
                else chk("orphan", 64'(orphan), 64'(exp_orph.pop_front()));
            end
        end
    end

    initial begin
        logic [2:0] g;
        logic [2:0] prev;
        g    = '0;
        prev = '0;
        for (int h = 0; h < NH; h++) begin
            bif.host_addr_i[h]  = 32'h80 * (h + 1);
            bif.host_we_i[h]    = (h == 2);
            bif.host_be_i[h]    = 4'b0001 << h;
            bif.host_wdata_i[h] = 32'hA000 + h;
        end

        // Reset with requests and a stray response present
        rst_n = 1'b0;
        idle();
        bif.host_req_i   = 3'b111;
        bif.dev_gnt_i    = 1'b1;
        bif.dev_rvalid_i = 1'b1;
        step();
        #3;
        chk("rst_dev_req", 64'(bif.dev_req_o), 64'(0));
        chk("rst_gnt", 64'(bif.host_gnt_o), 64'(0));
        chk("rst_rvalid", 64'(bif.host_rvalid_o), 64'(0));
        chk("rst_orphan", 64'(orphan), 64'(0));
        step(); idle(); rst_n = 1'b1;
        #3;
        chk("idle_dev_req", 64'(bif.dev_req_o), 64'(0));
        chk("idle_addr", 64'(bif.dev_addr_o), 64'(0));

        // Single host read
        step(); idle();
        bif.host_req_i = 3'b010; bif.dev_gnt_i = 1'b1;
        exp_gnt.push_back(3'b010);
        #3;
        chk("t1_dev_req", 64'(bif.dev_req_o), 64'(1));
        chk("t1_addr", 64'(bif.dev_addr_o), 64'h100);
        chk("t1_be", 64'(bif.dev_be_o), 64'(4'b0010));
        step(); idle();
        bif.dev_rvalid_i = 1'b1; bif.dev_rdata_i = 32'hDEADBEEF;
        exp_rsp.push_back(mk_rsp(3'b010, 32'hDEADBEEF, 3'b000));
        step(); idle();

        // Contention between hosts 0 and 2, back-to-back with next-cycle responses
        rst_n = 1'b0;
        step(); idle(); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); idle();
`ifdef BUS_ARB_ROUND_ROBIN_EN
            g = (i % 2 == 0) ? 3'b001 : 3'b100;
`else
            g = 3'b001;
`endif
            bif.host_req_i = 3'b101; bif.dev_gnt_i = 1'b1;
            exp_gnt.push_back(g);
            if (i > 0) begin
                bif.dev_rvalid_i = 1'b1; bif.dev_rdata_i = 32'h200 + i;
                exp_rsp.push_back(mk_rsp(prev, 32'h200 + i, 3'b000));
            end
            #3;
            chk("cont_dev_req", 64'(bif.dev_req_o), 64'(1));
            prev = g;
        end
        step(); idle();
        bif.dev_rvalid_i = 1'b1; bif.dev_rdata_i = 32'h2FF;
        exp_rsp.push_back(mk_rsp(prev, 32'h2FF, 3'b000));
        step(); idle();

        // Queue full: two grants, then blocked even while a response pops
        step(); idle();
        bif.host_req_i = 3'b010; bif.dev_gnt_i = 1'b1;
        exp_gnt.push_back(3'b010);
        step(); idle();
        bif.host_req_i = 3'b010; bif.dev_gnt_i = 1'b1;
        exp_gnt.push_back(3'b010);
        #3;
        chk("full_c2_req", 64'(bif.dev_req_o), 64'(1));
        step(); idle();
        bif.host_req_i = 3'b010; bif.dev_gnt_i = 1'b1;
        bif.dev_rvalid_i = 1'b1; bif.dev_rdata_i = 32'hA1;
        exp_rsp.push_back(mk_rsp(3'b010, 32'hA1, 3'b000));
        #3;
        chk("full_c3_req", 64'(bif.dev_req_o), 64'(0));
        chk("full_c3_gnt", 64'(bif.host_gnt_o), 64'(0));
        step(); idle();
        bif.host_req_i = 3'b010; bif.dev_gnt_i = 1'b1;
        exp_gnt.push_back(3'b010);
        #3;
        chk("full_c4_req", 64'(bif.dev_req_o), 64'(1));
        step(); idle();
        bif.dev_rvalid_i = 1'b1; bif.dev_rdata_i = 32'hA2;
        exp_rsp.push_back(mk_rsp(3'b010, 32'hA2, 3'b000));
        step(); idle();
        bif.dev_rvalid_i = 1'b1; bif.dev_rdata_i = 32'hA3;
        exp_rsp.push_back(mk_rsp(3'b010, 32'hA3, 3'b000));
        step(); idle();

        // Routing: host 2 (write) then host 0, responses in order, error on the second
        step(); idle();
        bif.host_req_i = 3'b100; bif.dev_gnt_i = 1'b1;
        exp_gnt.push_back(3'b100);
        #3;
        chk("rt_we", 64'(bif.dev_we_o), 64'(1));
        chk("rt_wdata", 64'(bif.dev_wdata_o), 64'hA002);
        step(); idle();
        bif.host_req_i = 3'b001; bif.dev_gnt_i = 1'b1;
        exp_gnt.push_back(3'b001);
        #3;
        chk("rt_addr", 64'(bif.dev_addr_o), 64'h80);
        step(); idle();
        bif.dev_rvalid_i = 1'b1; bif.dev_rdata_i = 32'h11;
        exp_rsp.push_back(mk_rsp(3'b100, 32'h11, 3'b000));
        step(); idle();
        bif.dev_rvalid_i = 1'b1; bif.dev_rdata_i = 32'h22; bif.dev_err_i = 1'b1;
        exp_rsp.push_back(mk_rsp(3'b001, 32'h22, 3'b001));
        step(); idle();
        #3;
        chk("rt_idle_rvalid", 64'(bif.host_rvalid_o), 64'(0));

        // Reset drops an outstanding ID; the late response is an orphan
        step(); idle();
        bif.host_req_i = 3'b010; bif.dev_gnt_i = 1'b1;
        exp_gnt.push_back(3'b010);
        step(); idle(); rst_n = 1'b0;
        step(); idle(); rst_n = 1'b1;
        bif.dev_rvalid_i = 1'b1; bif.dev_rdata_i = 32'h33;
        exp_orph.push_back(1'b1);
        #3;
        chk("orph_pulse", 64'(orphan), 64'(1));
        chk("orph_rvalid", 64'(bif.host_rvalid_o), 64'(0));
        step(); idle();
        #3;
        chk("orph_clear", 64'(orphan), 64'(0));

        step(); step();
        chk("gnt_left", 64'(exp_gnt.size()), 64'(0));
        chk("rsp_left", 64'(exp_rsp.size()), 64'(0));
        chk("orph_left", 64'(exp_orph.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_host_arbiter.md
# bus_host_arbiter

Arbitrates a set of bus hosts (core instruction port, core data port, test utility host) onto one shared downstream device port and routes each response back to the host that issued it. Tracks outstanding transactions in an in-order ID queue so pipelined requests never return to the wrong host. Sits between the host ports and a single-ported device such as the RAM, replacing fixed wiring when several hosts share one memory.

## Interface
- `NrHosts`, default 3: number of requesters, 2..8.
- `DataWidth`, default 32: data bus width.
- `AddrWidth`, default 32: address width.
- `MaxOutstanding`, default 2: depth of the response-routing queue, 1..8.

- `clk_i`  in  1  clock; all logic on its rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `host_req_i`  in  [NrHosts]  per-host request; held until granted.
- `host_gnt_o`  out  [NrHosts]  per-host grant, one-hot or zero.
- `host_addr_i`, `host_we_i`, `host_be_i`, `host_wdata_i`  in  [NrHosts] x AddrWidth/1/DataWidth/8/DataWidth  per-host command.
- `host_rvalid_o`  out  [NrHosts]  per-host response valid, one-hot or zero.
- `host_rdata_o`  out  [NrHosts] x DataWidth  response data; the same value to all hosts.
- `host_err_o`  out  [NrHosts]  response error, qualified by `host_rvalid_o`.
- `dev_req_o`  out  1  device request.
- `dev_gnt_i`  in  1  device accepts the request this cycle.
- `dev_addr_o`, `dev_we_o`, `dev_be_o`, `dev_wdata_o`  out  command of the selected host.
- `dev_rvalid_i`, `dev_rdata_i`, `dev_err_i`  in  device response; in order, one per accepted request.
- `orphan_o`  out  1  one-cycle pulse when `dev_rvalid_i` arrives with the queue empty.

## Operation
- Combinational selection each cycle among the asserted `host_req_i` bits. A request is eligible only when `count < MaxOutstanding`.
- `dev_req_o` = eligible and any request. Command fields are muxed from the selected host. With no selection the fields are driven to 0.
- `host_gnt_o[sel]` = `dev_req_o & dev_gnt_i`. Handshake = grant high. On a handshake, `sel` is pushed into the ID queue.
- The ID queue is a FIFO of `$clog2(NrHosts)`-bit IDs, depth MaxOutstanding, with `count` from 0 to MaxOutstanding.
- On `dev_rvalid_i` with `count>0`: the head ID is popped, and `host_rvalid_o[head]` and `host_err_o[head]` are driven from `dev_rvalid_i`/`dev_err_i` in the same cycle.
- Response data passes straight through, with no buffering.
- Push and pop in the same cycle: `count` unchanged, pointers both advance. Pointers wrap modulo MaxOutstanding.
- On `dev_rvalid_i` with `count==0`: no host `rvalid`, `orphan_o`=1 for that cycle, state unchanged.
- Arbitration policy is set by the macro (see Configuration). The round-robin pointer `last` updates only on a handshake.

## Timing
- Reset values: `host_gnt_o`=0, `host_rvalid_o`=0, `host_err_o`=0, `dev_req_o`=0, `orphan_o`=0, `count`=0, queue pointers=0, `last`=NrHosts-1.
- Reset mid-transaction drops all outstanding IDs. Responses arriving after reset produce `orphan_o`.
- Paths `host_req_i`→`dev_req_o` and `dev_gnt_i`→`host_gnt_o` are combinational, giving 0-cycle grant latency.
- `dev_rvalid_i`→`host_rvalid_o` is combinational. The queue state updates on the next edge.
- When full (`count==MaxOutstanding`), `dev_req_o`=0 even if the same cycle pops. There is no combinational path from `dev_rvalid_i` to grant.
- Sustained throughput is one transaction per cycle when the device responds within MaxOutstanding-1 cycles.

## Configuration
- `BUS_ARB_ROUND_ROBIN_EN` defined: round-robin. The search starts at `last+1` mod NrHosts, and the winner becomes `last` on handshake.
- `BUS_ARB_ROUND_ROBIN_EN` undefined: fixed priority, where the lowest index wins (TestUtilHost=0 highest). `last` is not implemented.

## Test plan
- Single host: host 1 requests addr 0x100, device grants and responds next cycle with 0xDEADBEEF → `host_gnt_o`=3'b010, then `host_rvalid_o`=3'b010 with `rdata`=0xDEADBEEF.
- Contention with RR enabled: hosts 0 and 2 request continuously, device always grants → grants alternate 0,2,0,2 starting with host 0 after reset. With the macro off, host 0 wins every cycle.
- Queue full with MaxOutstanding=2: two grants and no responses → `dev_req_o`=0 in cycle 3. A response in cycle 3 re-enables `dev_req_o` in cycle 4.
- Response routing: grants to host 2 then host 0, responses 0x11 then 0x22 with `err` on the second → host 2 gets 0x11 with err=0, host 0 gets 0x22 with err=1.
- Orphan/reset: issue a grant, pulse `rst_ni` low for one cycle, then drive `dev_rvalid_i` → `orphan_o`=1 for one cycle and no `host_rvalid_o`.
- Simultaneous push/pop at `count`=1 → `count` stays 1, and the IDs come out in issue order over 10 back-to-back transfers.
